idct_col_pass: RTL

//  Second (column) 1-D inverse transform pass of the 2-D IDCT. It sits directly after the

---
 rtl/idct_col_pass.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/idct_col_pass.sv
// ============================================================================
// Module   : idct_col_pass
// Purpose  : Column (second) pass of the 2-D H.265 IDCT. It collects one 4- or
//            8-sample column from the transpose stream, multiplies it by the
//            integer DCT basis, rounds, shifts and saturates each result, and
//            emits one residual per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module idct_col_pass #(
   parameter int WIDTH_X = 16,
   parameter int WIDTH_Y = 9,
   parameter int SHIFT   = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                idct4_in,
   input  logic signed [WIDTH_X-1:0] d_in,
   output logic [1:0]                idct4_out,
   output logic                      valid_out,
   output logic signed [WIDTH_Y-1:0] d_out
);

   localparam int ACC_W = WIDTH_X + 11;
   localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1 << (SHIFT - 1));
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << (WIDTH_Y - 1)) - 1);
   localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(1 << (WIDTH_Y - 1)));

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_EMIT = 1'b1;

   // 8-point basis, T8[row*8 + n]. The 4-point basis is rows 0,2,4,6 (n < 4).
   localparam logic signed [7:0] T8 [64] = '{
      8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,
      8'sd89,  8'sd75,  8'sd50,  8'sd18, -8'sd18, -8'sd50, -8'sd75, -8'sd89,
      8'sd83,  8'sd36, -8'sd36, -8'sd83, -8'sd83, -8'sd36,  8'sd36,  8'sd83,
      8'sd75, -8'sd18, -8'sd89, -8'sd50,  8'sd50,  8'sd89,  8'sd18, -8'sd75,
      8'sd64, -8'sd64, -8'sd64,  8'sd64,  8'sd64, -8'sd64, -8'sd64,  8'sd64,
      8'sd50, -8'sd89,  8'sd18,  8'sd75, -8'sd75, -8'sd18,  8'sd89, -8'sd50,
      8'sd36, -8'sd83,  8'sd83, -8'sd36, -8'sd36,  8'sd83, -8'sd83,  8'sd36,
      8'sd18, -8'sd50,  8'sd75, -8'sd89,  8'sd89, -8'sd75,  8'sd50, -8'sd18
   };

   // ---------------- collection ----------------
   logic [1:0]                prev_flag;
   logic [2:0]                cnt;
   logic signed [WIDTH_X-1:0] col [8];
   logic signed [WIDTH_X-1:0] full [8];
   logic                      in_valid;
   logic [2:0]                in_last;
   logic                      restart;
   logic                      load;

   assign in_valid = (idct4_in == 2'b01) || (idct4_in == 2'b10);
   assign in_last  = (idct4_in == 2'b10) ? 3'd7 : 3'd3;
   // A size switch mid-column restarts collection with the current sample as X[0].
   assign restart  = in_valid && (cnt != 3'd0) && (idct4_in != prev_flag);
   assign load     = in_valid && !restart && (cnt == in_last);

   // Complete column as it will be after this edge (current sample merged in).
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         full[k] = (3'(k) == cnt) ? d_in : col[k];
      end
   end

   // Sample capture and column counting; idle or flag change drops a partial column.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_flag <= 2'b00;
         cnt       <= 3'd0;
         for (int k = 0; k < 8; k++) col[k] <= '0;
      end else begin
         prev_flag <= idct4_in;
         if (!in_valid) begin
            cnt <= 3'd0;
         end else if (restart) begin
            col[0] <= d_in;
            cnt    <= 3'd1;
         end else begin
            col[cnt] <= d_in;
            cnt      <= load ? 3'd0 : cnt + 3'd1;
         end
      end
   end

   // ---------------- output sequencer ----------------
   logic [0:0]                state;
   logic [2:0]                idx;
   logic [2:0]                cur_last;
   logic [1:0]                cur_flag;
   logic signed [WIDTH_X-1:0] work [8];
   logic                      pend;
   logic [2:0]                pend_last;
   logic [1:0]                pend_flag;
   logic signed [WIDTH_X-1:0] shadow [8];
   logic                      free;

   // The sequencer can take a new column when idle or on its last index.
   assign free = (state == ST_IDLE) || (idx == cur_last);

   // Column hand-off: a column arriving while a longer one is still emitting waits
   // in the shadow buffer so the column in flight is never overwritten.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         idx       <= 3'd0;
         cur_last  <= 3'd0;
         cur_flag  <= 2'b00;
         pend      <= 1'b0;
         pend_last <= 3'd0;
         pend_flag <= 2'b00;
         for (int k = 0; k < 8; k++) begin
            work[k]   <= '0;
            shadow[k] <= '0;
         end
      end else if (free) begin
         idx <= 3'd0;
         if (pend) begin
            work     <= shadow;
            cur_last <= pend_last;
            cur_flag <= pend_flag;
            state    <= ST_EMIT;
            if (load) begin
               shadow    <= full;
               pend_last <= in_last;
               pend_flag <= idct4_in;
            end else begin
               pend <= 1'b0;
            end
         end else if (load) begin
            work     <= full;
            cur_last <= in_last;
            cur_flag <= idct4_in;
            state    <= ST_EMIT;
         end else begin
            state <= ST_IDLE;
         end
      end else begin
         idx <= idx + 3'd1;
         if (load) begin
            shadow    <= full;
            pend      <= 1'b1;
            pend_last <= in_last;
            pend_flag <= idct4_in;
         end
      end
   end

   // ---------------- datapath ----------------
   logic signed [ACC_W-1:0] sum;
   logic [2:0]              row;
   logic [5:0]              tidx;

   // Dot product of the working column with basis column idx.
   always_comb begin
      sum  = '0;
      row  = 3'd0;
      tidx = 6'd0;
      for (int k = 0; k < 8; k++) begin
         row  = (cur_last == 3'd7) ? 3'(k) : 3'(2 * k);
         tidx = {row, idx};
         if (3'(k) <= cur_last) begin
            sum = sum + ACC_W'(work[k]) * ACC_W'(T8[tidx]);
         end
      end
   end

   logic signed [ACC_W-1:0]   acc;
   logic                      s1_valid;
   logic [1:0]                s1_flag;
   logic signed [ACC_W-1:0]   shifted;
   logic signed [WIDTH_Y-1:0] satv;

   // First pipeline stage: register the accumulated sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         s1_valid <= 1'b0;
         s1_flag  <= 2'b00;
      end else begin
         acc      <= sum;
         s1_valid <= (state == ST_EMIT);
         s1_flag  <= cur_flag;
      end
   end

   // Round half-up, arithmetic shift, clamp to the residual range.
   always_comb begin
      shifted = (acc + RND) >>> SHIFT;
      if (shifted > MAXV)      satv = MAXV[WIDTH_Y-1:0];
      else if (shifted < MINV) satv = MINV[WIDTH_Y-1:0];
      else                     satv = shifted[WIDTH_Y-1:0];
   end

   // Output register: data and flag hold their last value between columns.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_out <= 1'b0;
         d_out     <= '0;
         idct4_out <= 2'b00;
      end else begin
         valid_out <= s1_valid;
         if (s1_valid) begin
            d_out     <= satv;
            idct4_out <= s1_flag;
         end
      end
   end

endmodule

`default_nettype wire
